// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the non-stalling pipeline writeback
// and a FIFO of long-latency results, and keeps a per-register busy scoreboard.
module regfile_wb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     p_we,
   input  logic [4:0]               p_rd,
   input  logic [DATA_W-1:0]        p_data,
   input  logic                     m_valid,
   output logic                     m_ready,
   input  logic [4:0]               m_rd,
   input  logic [DATA_W-1:0]        m_data,
   input  logic                     iss_valid,
   input  logic [4:0]               iss_rd,
   input  logic [4:0]               chk_rs,
   input  logic [4:0]               chk_rt,
   input  logic [4:0]               chk_rd,
   output logic                     hazard,
   output logic                     RegWrite,
   output logic [4:0]               wt_register,
   output logic [DATA_W-1:0]        wt_data,
   output logic [31:0]              busy,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [4:0]        rd_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic [31:0]       busy_q, busy_next, set_mask, clr_mask;
   logic              p_own, fifo_empty, push, pop;
   logic [4:0]        head_rd;

   assign p_own      = p_we && (p_rd != 5'd0);
   assign fifo_empty = (count_q == '0);
   assign m_ready    = (count_q < FULL_CNT);
   assign push       = m_valid && m_ready && (m_rd != 5'd0);
   assign pop        = !p_own && !fifo_empty;
   assign head_rd    = rd_mem[rd_ptr_q];

   // Pipeline has absolute priority; the FIFO head only fills idle write slots.
   always_comb begin
      RegWrite    = 1'b0;
      wt_register = '0;
      wt_data     = '0;
      if (rst_n) begin
         if (p_own) begin
            RegWrite    = 1'b1;
            wt_register = p_rd;
            wt_data     = p_data;
         end else if (!fifo_empty) begin
            RegWrite    = 1'b1;
            wt_register = head_rd;
            wt_data     = data_mem[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr_q]   <= m_rd;
         data_mem[wr_ptr_q] <= m_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Set is applied after clear so a same-cycle re-issue keeps the register busy.
   always_comb begin
      set_mask  = (iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
      clr_mask  = pop ? (32'd1 << head_rd) : 32'd0;
      busy_next = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_next;
   end

   assign busy    = busy_q;
   assign pending = count_q;
   assign hazard  = busy_q[chk_rs] | busy_q[chk_rt] | busy_q[chk_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p_we, m_valid, iss_valid;
   logic [4:0]  p_rd, m_rd, iss_rd, chk_rs, chk_rt, chk_rd;
   logic [31:0] p_data, m_data;
   logic        m_ready, hazard, RegWrite;
   logic [4:0]  wt_register;
   logic [31:0] wt_data, busy;
   logic [1:0]  pending;

   int checks = 0;
   int fails  = 0;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .p_we(p_we), .p_rd(p_rd), .p_data(p_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd), .hazard(hazard),
      .RegWrite(RegWrite), .wt_register(wt_register), .wt_data(wt_data),
      .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending results as a queue, busy registers as a bit array.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] mb;

   initial begin : model
      bit          pown;
      logic        e_we;
      logic [4:0]  e_reg;
      logic [31:0] e_dat;
      int          sz;
      mb = '0;
      forever begin
         @(negedge clk);
         pown = p_we && (p_rd != 0);
         if (!rst_n) begin
            chk("m_we", RegWrite, 0);
            chk("m_reg", wt_register, 0);
            chk("m_dat", wt_data, 0);
            chk("m_rdy", m_ready, 1);
            chk("m_pend", pending, 0);
            chk("m_busy", busy, 0);
            chk("m_haz", hazard, 0);
         end else begin
            e_we  = pown || (mq.size() > 0);
            e_reg = pown ? p_rd : (mq.size() > 0 ? mq[0].rd : 5'd0);
            e_dat = pown ? p_data : (mq.size() > 0 ? mq[0].d : 32'd0);
            chk("m_we", RegWrite, e_we);
            chk("m_reg", wt_register, e_reg);
            chk("m_dat", wt_data, e_dat);
            chk("m_rdy", m_ready, mq.size() < DEPTH);
            chk("m_pend", pending, mq.size());
            chk("m_busy", busy, mb);
            chk("m_haz", hazard, mb[chk_rs] | mb[chk_rt] | mb[chk_rd]);
         end
         @(posedge clk);
         if (!rst_n) begin
            mq.delete();
            mb = '0;
         end else begin
            pown = p_we && (p_rd != 0);
            sz   = mq.size();
            if (!pown && sz > 0) begin
               mb[mq[0].rd] = 1'b0;
               void'(mq.pop_front());
            end
            if (m_valid && sz < DEPTH && m_rd != 0) mq.push_back('{rd: m_rd, d: m_data});
            if (iss_valid && iss_rd != 0) mb[iss_rd] = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p_we = 0; p_rd = 0; p_data = 0;
      m_valid = 0; m_rd = 0; m_data = 0;
      iss_valid = 0; iss_rd = 0;
      chk_rs = 0; chk_rt = 0; chk_rd = 0;
   endtask

   logic       c_pwe  [6] = '{1, 1, 1, 0, 0, 0};
   logic [4:0] c_prd  [6] = '{1, 2, 4, 0, 0, 0};
   logic       c_mv   [6] = '{1, 1, 0, 0, 0, 0};
   logic [4:0] c_mrd  [6] = '{8, 9, 0, 0, 0, 0};
   logic       c_ewe  [6] = '{1, 1, 1, 1, 1, 0};
   logic [4:0] c_ereg [6] = '{1, 2, 4, 8, 9, 0};
   logic [1:0] c_epnd [6] = '{0, 1, 2, 2, 1, 0};
   logic       c_erdy [6] = '{1, 1, 0, 0, 1, 1};

   initial begin : driver
      idle();
      rst_n = 0; p_we = 1; p_rd = 5;
      @(negedge clk);
      chk("rst_we", RegWrite, 0);
      chk("rst_rdy", m_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pend", pending, 0);
      step();
      rst_n = 1; idle();
      step();

      // Pipeline write, then a write to r0
      p_we = 1; p_rd = 3; p_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("pw_we", RegWrite, 1);
      chk("pw_reg", wt_register, 3);
      chk("pw_dat", wt_data, 32'hDEADBEEF);
      step();
      p_rd = 0;
      @(negedge clk);
      chk("pw_r0_we", RegWrite, 0);
      step();
      idle();

      // Long op to r7
      iss_valid = 1; iss_rd = 7;
      step();
      iss_valid = 0; chk_rs = 7;
      @(negedge clk);
      chk("lo_busy7", busy[7], 1);
      chk("lo_haz", hazard, 1);
      step();
      m_valid = 1; m_rd = 7; m_data = 32'h1234;
      @(negedge clk);
      chk("lo_nobypass", RegWrite, 0);
      step();
      m_valid = 0;
      @(negedge clk);
      chk("lo_we", RegWrite, 1);
      chk("lo_reg", wt_register, 7);
      chk("lo_dat", wt_data, 32'h1234);
      step();
      @(negedge clk);
      chk("lo_busy7_clr", busy[7], 0);
      chk("lo_haz_clr", hazard, 0);
      step();
      idle();

      // Contention: pipeline keeps the port while r8, r9 wait
      for (int i = 0; i < 6; i++) begin
         p_we = c_pwe[i]; p_rd = c_prd[i]; p_data = 32'h100 + i;
         m_valid = c_mv[i]; m_rd = c_mrd[i]; m_data = {27'd0, c_mrd[i]} * 32'h11;
         @(negedge clk);
         chk($sformatf("ct_we%0d", i), RegWrite, c_ewe[i]);
         chk($sformatf("ct_reg%0d", i), wt_register, c_ereg[i]);
         chk($sformatf("ct_pend%0d", i), pending, c_epnd[i]);
         chk($sformatf("ct_rdy%0d", i), m_ready, c_erdy[i]);
         step();
      end
      idle();

      // r0 result is accepted and dropped
      m_valid = 1; m_rd = 0; m_data = 32'h5;
      @(negedge clk);
      chk("r0_rdy", m_ready, 1);
      step();
      idle();
      @(negedge clk);
      chk("r0_pend", pending, 0);
      chk("r0_we", RegWrite, 0);
      step();

      // Same-cycle set and clear of r10
      iss_valid = 1; iss_rd = 10;
      step();
      iss_valid = 0; m_valid = 1; m_rd = 10; m_data = 32'hAA;
      step();
      m_valid = 0; iss_valid = 1; iss_rd = 10;
      @(negedge clk);
      chk("sc_reg", wt_register, 10);
      step();
      idle();
      @(negedge clk);
      chk("sc_busy10", busy[10], 1);
      chk("sc_pend", pending, 0);
      step();

      // Mid-operation reset with two queued entries
      iss_valid = 1; iss_rd = 5;
      step();
      iss_rd = 6; p_we = 1; p_rd = 1; m_valid = 1; m_rd = 5; m_data = 32'h55;
      step();
      iss_valid = 0; p_rd = 2; m_rd = 6; m_data = 32'h66;
      step();
      p_rd = 3; m_valid = 0;
      @(negedge clk);
      chk("mr_pend_pre", pending, 2);
      chk("mr_busy_pre", busy & 32'h60, 32'h60);
      #2;
      rst_n = 0;
      #1;
      chk("mr_pend", pending, 0);
      chk("mr_busy", busy, 0);
      chk("mr_we", RegWrite, 0);
      step();
      step();
      idle();
      rst_n = 1;
      step();
      @(negedge clk);
      chk("mr_post_we", RegWrite, 0);
      chk("mr_post_pend", pending, 0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It shares the file's single write port (`wt_register`/`wt_data`/`RegWrite`, captured on posedge) between two sources: the in-order pipeline writeback, which cannot stall, and a long-latency unit (mul/div/load return), which uses a valid/ready handshake. Long-latency results wait in a small FIFO. A per-register busy scoreboard lets decode stall on outstanding destinations.

## Interface
- `DEPTH`, 2, number of FIFO entries for long-latency results (power of two, ≥2).
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p_we` in 1: pipeline writeback valid.
- `p_rd` in 5: pipeline destination register.
- `p_data` in 32: pipeline write data.
- `m_valid` in 1: long-latency result valid.
- `m_ready` out 1: long-latency result accepted this cycle when high together with `m_valid`.
- `m_rd` in 5: long-latency destination register.
- `m_data` in 32: long-latency result data.
- `iss_valid` in 1: a long-latency op issues this cycle.
- `iss_rd` in 5: destination of the issuing op.
- `chk_rs`, `chk_rt`, `chk_rd` in 5 each: decode operands checked against the scoreboard.
- `hazard` out 1: an operand is busy; decode must stall.
- `RegWrite` out 1: register file write enable.
- `wt_register` out 5: register file write address.
- `wt_data` out 32: register file write data.
- `busy` out 32: scoreboard bit vector; bit 0 is always 0.
- `pending` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Register 0** is never written and never busy.
  - Pipeline writes with `p_rd`=0 produce no `RegWrite`.
  - Long-latency results with `m_rd`=0 are handshaked (accepted) and dropped, not enqueued.
- **FIFO accept:** `m_ready` = (`pending` < DEPTH). On `m_valid`&`m_ready` with `m_rd`≠0, {`m_rd`, `m_data`} is pushed at posedge.
- **Write-port selection** is combinational and evaluated each cycle:
  1. If `p_we` & `p_rd`≠0, the pipeline owns the port: `RegWrite`=1, `wt_register`=`p_rd`, `wt_data`=`p_data`. The FIFO does not pop.
  2. Otherwise, if the FIFO is non-empty, the head drives the port with `RegWrite`=1, and the head is popped at posedge.
  3. Otherwise, `RegWrite`=0, and `wt_register`/`wt_data` are 0.
- **No bypass:** a result is never written in the same cycle it is accepted.
- **Simultaneous push and pop:** allowed. `pending` is unchanged. Push while full is impossible because `m_ready`=0.
- **Scoreboard:**
  - A busy bit is set at posedge when `iss_valid` & `iss_rd`≠0.
  - A busy bit is cleared at posedge when the FIFO pops an entry for that register.
  - If set and clear hit the same register in the same cycle, set wins.
  - A pipeline write to a busy register is performed and does not change `busy`.
- **hazard** = `busy[chk_rs]` | `busy[chk_rt]` | `busy[chk_rd]`, combinational. Issue must not occur while `hazard`=1; this is the issuer's responsibility.

## Timing
- **Reset (`rst_n`=0, asynchronous):**
  - FIFO emptied (`pending`=0), `busy`=0.
  - `m_ready`=1, `hazard`=0.
  - `RegWrite`=0, `wt_register`=0, `wt_data`=0. Outputs are gated low while reset is asserted, regardless of `p_we`.
- **Reset mid-operation:** queued results are discarded and busy bits cleared; nothing is written.
- **Latency:**
  - Pipeline write: 0 cycles. It is presented the same cycle and captured at that posedge, so it is visible to the register file's following negedge read.
  - Long-latency result: minimum 1 cycle from accept to `RegWrite`. Each cycle the pipeline writes adds one cycle of delay, unbounded, because the pipeline has absolute priority.
- **Ordering:** FIFO entries are written strictly in acceptance order.
- **Busy clear timing:** the busy bit clears at the same posedge that writes the data, so `hazard` drops one cycle after that write is presented.

## Test plan
- **Reset:** assert `rst_n`=0 with `p_we`=1, `p_rd`=5 → `RegWrite`=0, `m_ready`=1, `busy`=0, `pending`=0.
- **Pipeline write:** `p_we`=1, `p_rd`=3, `p_data`=0xDEADBEEF → same cycle `RegWrite`=1, `wt_register`=3, `wt_data`=0xDEADBEEF. Then `p_rd`=0 → `RegWrite`=0.
- **Long op, single result:** issue `iss_rd`=7 → `busy[7]`=1, and `hazard`=1 for `chk_rs`=7. Push `m_rd`=7, `m_data`=0x1234 → next cycle `RegWrite`=1, `wt_register`=7. After that edge `busy[7]`=0 and `hazard`=0.
- **Contention:** push results for r8 then r9 while `p_we`=1 for 3 cycles to r1/r2/r4.
  - Ports show r1, r2, r4, r8, r9 in that order.
  - `pending` sequence 1, 2, 2, 1, 0.
  - `m_ready`=0 while `pending`=2 (DEPTH=2).
- **Simultaneous set and clear:** FIFO pops r10 in the same cycle as `iss_valid`, `iss_rd`=10 → `busy[10]` stays 1.
- **Mid-operation reset:** reset with 2 entries queued and `busy[5]`, `busy[6]` set → no writes occur, `pending`=0, `busy`=0 immediately.
